// File: rtl/demux8_deser.sv
// demux8_deser: serial-to-parallel byte assembler with valid/ready output; DEMUX8_DESER_PARITY_EN adds an even-parity bit per frame.
module demux8_deser #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic       overrun,
  output logic       parity_err
);
`ifdef DEMUX8_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_t;
  logic perr, perr_n;
`else
  typedef enum logic [0:0] {IDLE, COLLECT} state_t;
`endif
  state_t state, state_n;
  logic [2:0] sel_n, slot, pos;
  logic [7:0] word, word_n;
  logic wr, deliver;
  always_comb begin
    state_n = state;
    sel_n = sel;
    slot = sel;
    wr = 1'b0;
    deliver = 1'b0;
`ifdef DEMUX8_DESER_PARITY_EN
    perr_n = 1'b0;
`endif
    if (in_valid && in_sof) begin
      state_n = COLLECT;
      sel_n = 3'd1;
      slot = 3'd0;
      wr = 1'b1;
    end else if (in_valid && state == COLLECT) begin
      wr = 1'b1;
      sel_n = sel + 3'd1;
`ifdef DEMUX8_DESER_PARITY_EN
      state_n = (sel == 3'd7) ? PARITY : COLLECT;
`else
      state_n = (sel == 3'd7) ? IDLE : COLLECT;
      deliver = (sel == 3'd7);
`endif
    end
`ifdef DEMUX8_DESER_PARITY_EN
    else if (in_valid && state == PARITY) begin
      state_n = IDLE;
      deliver = ~^{word, in_bit};
      perr_n = ^{word, in_bit};
    end
`endif
    pos = MSB_FIRST ? 3'd7 - slot : slot;
    word_n = word;
    if (wr) word_n[pos] = in_bit;
  end
  // A word arriving while the previous one is still unconsumed is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= 3'd0;
      word <= 8'h00;
      out_data <= 8'h00;
      out_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      word <= word_n;
      if (deliver && !(out_valid && !out_ready)) out_data <= word_n;
      out_valid <= deliver || (out_valid && !out_ready);
      overrun <= overrun || (deliver && out_valid && !out_ready);
    end
  end
`ifdef DEMUX8_DESER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) perr <= 1'b0;
    else perr <= perr_n;
  end
  assign parity_err = perr;
`else
  assign parity_err = 1'b0;
`endif
endmodule
